// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory responder: command encodings on the
// control-unit bus and the FSM state type.
package cpu_pkg;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;
  localparam logic [7:0] CMD_IDLE  = 8'hFF;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/data_memory_unit_if.sv
// Command/address/status signals between the control unit (master) and the
// data-memory unit (slave). The shared data bus is a plain inout port on the
// memory unit so that tri-state resolution stays on an ordinary net.
interface data_memory_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] cmd_memory;
  logic [ADDR_W-1:0] addr_memory;
  logic              busy;

  modport master (
    output cmd_memory,
    output addr_memory,
    input  busy
  );

  modport slave (
    input  cmd_memory,
    input  addr_memory,
    output busy
  );
endinterface

// File: rtl/data_memory_unit_dmem_array.sv
// Storage array: asynchronous read port, one synchronous write port, no reset
// so the contents survive a reset of the surrounding control logic.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Single write port, committed on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_unit.sv
// Responder on the control unit's data-memory port: decodes READ/WRITE/CLEAR,
// drives the shared bus on READ, guards against repeated commits of a held
// WRITE, and sweeps the array to zero on CLEAR while reporting busy.
module data_memory_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  data_memory_unit_if.slave mem_if,
  inout  wire  [DATA_W-1:0] data_memory
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

  dmem_state_t       state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_cmd_q, prev_cmd_d;
  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
  logic              busy_q, busy_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              drive_en;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (mem_if.addr_memory),
    .rdata (rdata)
  );

  // Next-state, sweep counter, write-guard history and array write decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    prev_cmd_d  = mem_if.cmd_memory;
    prev_addr_d = mem_if.addr_memory;
    we          = 1'b0;
    waddr       = mem_if.addr_memory;
    wdata       = data_memory;
    case (state_q)
      S_IDLE: begin
        // The control unit releases the bus while still presenting WRITE, so
        // only the first cycle of a WRITE at a given address may commit.
        if (mem_if.cmd_memory == DATA_W'(CMD_WRITE) &&
            (prev_cmd_q != DATA_W'(CMD_WRITE) ||
             mem_if.addr_memory != prev_addr_q)) begin
          we = 1'b1;
        end
        if (mem_if.cmd_memory == DATA_W'(CMD_CLEAR)) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_CLEAR: begin
        // Commands are ignored here, including on the final sweep edge.
        we    = 1'b1;
        waddr = cnt_q[ADDR_W-1:0];
        wdata = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; the array itself is deliberately outside the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      prev_cmd_q  <= DATA_W'(CMD_IDLE);
      prev_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      prev_cmd_q  <= prev_cmd_d;
      prev_addr_q <= prev_addr_d;
    end
  end

  assign drive_en    = (state_q == S_IDLE) &&
                       (mem_if.cmd_memory == DATA_W'(CMD_READ));
  assign data_memory = drive_en ? rdata : {DATA_W{1'bz}};
  assign mem_if.busy = busy_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit. The shared bus carries a pull-up, so an
// undriven bus reads 8'hFF; stored values used in high-Z checks avoid 8'hFF.
module tb_data_memory_unit;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       tb_oe;
  logic [7:0] tb_drv;
  wire  [7:0] data_bus;
  int         checks;
  int         errors;

  data_memory_unit_if #(.ADDR_W(8), .DATA_W(8)) dif ();

  data_memory_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_if      (dif.slave),
    .data_memory (data_bus)
  );

  assign data_bus = tb_oe ? tb_drv : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup pu (data_bus[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] c, input logic [7:0] a,
                       input logic oe, input logic [7:0] d);
    @(negedge clk);
    dif.cmd_memory  = c;
    dif.addr_memory = a;
    tb_oe           = oe;
    tb_drv          = d;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    drive(CMD_WRITE, a, 1'b1, d);
    drive(CMD_IDLE, a, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.cmd_memory  = CMD_IDLE;
    dif.addr_memory = 8'h00;
    tb_oe  = 1'b0;
    tb_drv = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", dif.busy);
    end
    checks++;
    if (data_bus !== 8'hFF) begin
      errors++; $display("FAIL reset_bus got %h want ff (undriven)", data_bus);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    drive(CMD_WRITE, 8'h10, 1'b1, 8'h5A);
    drive(CMD_IDLE, 8'h10, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'hFF) begin
      errors++; $display("FAIL wr_idle_bus got %h want ff (undriven)", data_bus);
    end
    drive(CMD_READ, 8'h10, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'h5A) begin
      errors++; $display("FAIL rd_10 got %h want 5a", data_bus);
    end
    drive(CMD_IDLE, 8'h10, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'hFF) begin
      errors++; $display("FAIL rd_release_bus got %h want ff (undriven)", data_bus);
    end
  endtask

  task automatic test_write_hold();
    drive(CMD_WRITE, 8'h20, 1'b1, 8'h11);
    drive(CMD_WRITE, 8'h20, 1'b0, 8'h00);
    drive(CMD_WRITE, 8'h20, 1'b0, 8'h00);
    drive(CMD_IDLE, 8'h20, 1'b0, 8'h00);
    drive(CMD_READ, 8'h20, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'h11) begin
      errors++; $display("FAIL hold_20 got %h want 11", data_bus);
    end
    drive(CMD_IDLE, 8'h20, 1'b0, 8'h00);
  endtask

  task automatic test_addr_step();
    drive(CMD_WRITE, 8'h30, 1'b1, 8'hAA);
    drive(CMD_WRITE, 8'h31, 1'b1, 8'hBB);
    drive(CMD_IDLE, 8'h31, 1'b0, 8'h00);
    drive(CMD_READ, 8'h30, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'hAA) begin
      errors++; $display("FAIL step_30 got %h want aa", data_bus);
    end
    drive(CMD_READ, 8'h31, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'hBB) begin
      errors++; $display("FAIL step_31 got %h want bb", data_bus);
    end
    drive(CMD_IDLE, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_clear();
    logic [7:0] addrs [4];
    int         busy_cnt;
    bit         done;
    addrs[0] = 8'h00; addrs[1] = 8'h80; addrs[2] = 8'hFF; addrs[3] = 8'h05;
    do_write(8'h00, 8'h12);
    do_write(8'h80, 8'h34);
    do_write(8'hFF, 8'h56);
    do_write(8'h50, 8'h77);
    drive(CMD_CLEAR, 8'h00, 1'b0, 8'h00);
    busy_cnt = 0;
    done     = 1'b0;
    for (int i = 1; i <= 400 && !done; i++) begin
      @(negedge clk);
      if (dif.busy === 1'b1) busy_cnt++;
      else done = 1'b1;
      if (!done) begin
        if (i == 1) begin
          dif.cmd_memory = CMD_IDLE;
        end else if (i == 10) begin
          dif.cmd_memory  = CMD_READ;
          dif.addr_memory = 8'h50;
          #2;
          checks++;
          if (data_bus !== 8'hFF) begin
            errors++; $display("FAIL clear_busy_bus got %h want ff (undriven)", data_bus);
          end
          dif.cmd_memory = CMD_IDLE;
        end else if (i == 200) begin
          dif.cmd_memory  = CMD_WRITE;
          dif.addr_memory = 8'h05;
          tb_oe  = 1'b1;
          tb_drv = 8'h99;
        end else if (i == 201) begin
          dif.addr_memory = 8'h06;
          tb_drv = 8'h98;
        end else if (i == 202) begin
          dif.cmd_memory = CMD_IDLE;
          tb_oe = 1'b0;
        end
      end
    end
    checks++;
    if (busy_cnt != 256 || !done) begin
      errors++; $display("FAIL clear_busy_len got %0d cycles want 256", busy_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      drive(CMD_READ, addrs[k], 1'b0, 8'h00);
      #2;
      checks++;
      if (data_bus !== 8'h00) begin
        errors++; $display("FAIL clear_rd_%h got %h want 00", addrs[k], data_bus);
      end
    end
    drive(CMD_IDLE, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_sweep();
    do_write(8'd5,   8'h21);
    do_write(8'd99,  8'h63);
    do_write(8'd100, 8'h64);
    do_write(8'd200, 8'h3C);
    drive(CMD_CLEAR, 8'h00, 1'b0, 8'h00);
    drive(CMD_IDLE, 8'h00, 1'b0, 8'h00);
    repeat (100) @(negedge clk);
    checks++;
    if (dif.busy !== 1'b1) begin
      errors++; $display("FAIL midrst_busy_before got %b want 1", dif.busy);
    end
    dif.cmd_memory  = CMD_READ;
    dif.addr_memory = 8'd200;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy_async got %b want 0", dif.busy);
    end
    checks++;
    if (data_bus !== 8'h3C) begin
      errors++; $display("FAIL midrst_rd_200 got %h want 3c", data_bus);
    end
    dif.cmd_memory = CMD_IDLE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(CMD_READ, 8'd5, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'h00) begin
      errors++; $display("FAIL midrst_rd_5 got %h want 00", data_bus);
    end
    drive(CMD_READ, 8'd99, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'h00) begin
      errors++; $display("FAIL midrst_rd_99 got %h want 00", data_bus);
    end
    drive(CMD_READ, 8'd100, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'h64) begin
      errors++; $display("FAIL midrst_rd_100 got %h want 64", data_bus);
    end
    drive(CMD_IDLE, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_illegal_cmd();
    do_write(8'h40, 8'h2B);
    drive(8'h07, 8'h40, 1'b1, 8'hE1);
    drive(8'h07, 8'h40, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'hFF) begin
      errors++; $display("FAIL illegal_bus got %h want ff (undriven)", data_bus);
    end
    drive(CMD_READ, 8'h40, 1'b0, 8'h00);
    #2;
    checks++;
    if (data_bus !== 8'h2B) begin
      errors++; $display("FAIL illegal_rd_40 got %h want 2b", data_bus);
    end
    drive(CMD_IDLE, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_write_hold();
    test_addr_step();
    test_clear();
    test_reset_mid_sweep();
    test_illegal_cmd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
